decode_hazard_stage: RTL

Parametrised decode stage for the pipelined processor: decodes the 5-bit opcode, reads a NREGS x DATA_W register file with write-through bypass, and registers operands and control into the ID/EX boundary. It also carries memory/writeback control down a WB_DEPTH-deep shift chain, detects load-use hazards (stall plus bubble) and squashes on a taken jump. It sits between fetch and execute, replacing the fixed-width 8x16 decode stage.

---
 rtl/decode_hazard_stage_pkg.sv | 110 +++++++++++
 rtl/decode_hazard_stage_if.sv | 60 ++++++
 rtl/decode_hazard_stage_regfile_bypass.sv | 46 ++++
 rtl/decode_hazard_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_stage_pkg.sv
// decode_pkg: opcode constants, the decoded control bundle and the
// opcode decoder shared by the decode stage.
//   ctrl_t  - control bits carried into the ID/EX register plus the
//             operand-usage flags consumed by hazard detection
//   decode  - pure function, 5-bit opcode in, ctrl_t out
package decode_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDD  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_STD  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_PUSH = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_POP  = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10100;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_JC   = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b11010;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_JZ   = 2'b01;
  localparam logic [1:0] JT_JC   = 2'b10;
  localparam logic [1:0] JT_JMP  = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    logic       push;
    logic       pop;
    logic       in;
    logic       out;
    logic [3:0] alu_op;
    logic [1:0] jump_type;
    logic       use_rs1;
    logic       use_rs2;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op[4:3])
      2'b00: begin
        // 00000 is NOP; every other 00xxx is a one-operand ALU op
        if (op != OP_NOP) begin
          c.alu_op  = {1'b0, op[2:0]};
          c.wb      = 1'b1;
          c.use_rs1 = 1'b1;
        end
      end
      2'b01: begin
        c.alu_op  = {1'b1, op[2:0]};
        c.wb      = 1'b1;
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
      end
      default: begin
        case (op)
          OP_LDD: begin
            c.mem_read = 1'b1;
            c.wb       = 1'b1;
            c.use_rs1  = 1'b1;
            c.use_rs2  = 1'b1;
          end
          OP_STD: begin
            c.mem_write = 1'b1;
            c.use_rs1   = 1'b1;
            c.use_rs2   = 1'b1;
          end
          OP_PUSH: begin
            c.push      = 1'b1;
            c.mem_write = 1'b1;
            c.use_rs1   = 1'b1;
          end
          OP_POP: begin
            c.pop      = 1'b1;
            c.mem_read = 1'b1;
            c.wb       = 1'b1;
            c.use_rs1  = 1'b1;
          end
          // IN only writes its destination, it reads no register
          OP_IN: begin
            c.in = 1'b1;
            c.wb = 1'b1;
          end
          OP_OUT: begin
            c.out     = 1'b1;
            c.use_rs1 = 1'b1;
          end
          OP_JZ: begin
            c.jump_type = JT_JZ;
            c.use_rs1   = 1'b1;
          end
          OP_JC: begin
            c.jump_type = JT_JC;
            c.use_rs1   = 1'b1;
          end
          OP_JMP: begin
            c.jump_type = JT_JMP;
            c.use_rs1   = 1'b1;
          end
          default: c = '0;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_hazard_stage_if.sv
// Bus bundle of the decode stage.
//   fetch side    : instr_valid, instruction, jump_occured in; stall out
//   writeback port: write_en, write_addr, write_data in
//   ID/EX register: ex_* out
//   chain taps    : mem_* (stage 2), wb_* (last stage) out
// master = the surrounding pipeline, slave = the decode stage.
interface decode_hazard_stage_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int INSTR_W = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               stall;
  logic               jump_occured;

  logic               write_en;
  logic [REG_AW-1:0]  write_addr;
  logic [DATA_W-1:0]  write_data;

  logic               ex_valid;
  logic [DATA_W-1:0]  ex_rdata1;
  logic [DATA_W-1:0]  ex_rdata2;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic [REG_AW-1:0]  ex_dest;
  logic [3:0]         ex_alu_op;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_wb;
  logic               ex_push;
  logic               ex_pop;
  logic               ex_in;
  logic               ex_out;
  logic [1:0]         ex_jump_type;

  logic               mem_valid;
  logic               mem_read;
  logic               mem_write;
  logic               mem_wb;
  logic [REG_AW-1:0]  mem_dest;

  logic               wb_valid;
  logic               wb_en;
  logic [REG_AW-1:0]  wb_dest;

  modport master (
    output instr_valid, instruction, jump_occured, write_en, write_addr, write_data,
    input  stall, ex_valid, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2, ex_dest, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_wb, ex_push, ex_pop, ex_in, ex_out, ex_jump_type,
           mem_valid, mem_read, mem_write, mem_wb, mem_dest, wb_valid, wb_en, wb_dest
  );

  modport slave (
    input  instr_valid, instruction, jump_occured, write_en, write_addr, write_data,
    output stall, ex_valid, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2, ex_dest, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_wb, ex_push, ex_pop, ex_in, ex_out, ex_jump_type,
           mem_valid, mem_read, mem_write, mem_wb, mem_dest, wb_valid, wb_en, wb_dest
  );
endinterface

// File: rtl/decode_hazard_stage_regfile_bypass.sv
// regfile_bypass: NREGS x DATA_W register file, two combinational read
// ports and one write port. A read of the address being written in the
// same cycle returns the incoming write data.
//   clk, reset (async, active-low, clears all registers)
//   write_en / write_addr / write_data : write port
//   raddr1 / rdata1, raddr2 / rdata2   : read ports
module regfile_bypass #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [REG_AW-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[write_addr] = write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (write_en && (write_addr == raddr1)) rdata1 = write_data;
    if (write_en && (write_addr == raddr2)) rdata2 = write_data;
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: decodes the fetched instruction, reads operands
// from the bypassed register file, detects load-use hazards and loads
// the ID/EX register. Memory/writeback control then walks down a
// never-stalling chain of WB_DEPTH-1 stages (indices 2..WB_DEPTH).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : decode_hazard_stage_if slave (fetch, writeback, ex/mem/wb)
// WB_DEPTH must be at least 2.
module decode_hazard_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int INSTR_W  = 16,
  parameter int WB_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  decode_hazard_stage_if.slave  bus
);

  localparam int REG_AW  = $clog2(NREGS);
  localparam int RS1_MSB = INSTR_W - OPCODE_W - 1;
  localparam int RS2_MSB = RS1_MSB - REG_AW;
  localparam int PAD_MSB = RS2_MSB - REG_AW;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              wb;
    logic [REG_AW-1:0] dest;
  } chain_t;

  logic [OPCODE_W-1:0] opcode;
  logic [REG_AW-1:0]   rs1;
  logic [REG_AW-1:0]   rs2;
  ctrl_t               dec;
  logic [DATA_W-1:0]   rf_rdata1;
  logic [DATA_W-1:0]   rf_rdata2;
  logic                hazard_match;
  logic                stall_int;

  logic                ex_valid_q,  ex_valid_d;
  ctrl_t               ex_ctrl_q,   ex_ctrl_d;
  logic [DATA_W-1:0]   ex_rdata1_q, ex_rdata1_d;
  logic [DATA_W-1:0]   ex_rdata2_q, ex_rdata2_d;
  logic [REG_AW-1:0]   ex_rs1_q,    ex_rs1_d;
  logic [REG_AW-1:0]   ex_rs2_q,    ex_rs2_d;
  logic [REG_AW-1:0]   ex_dest_q,   ex_dest_d;

  chain_t              chain_q [2:WB_DEPTH];
  chain_t              chain_d [2:WB_DEPTH];

  assign opcode = bus.instruction[INSTR_W-1 -: OPCODE_W];
  assign rs1    = bus.instruction[RS1_MSB -: REG_AW];
  assign rs2    = bus.instruction[RS2_MSB -: REG_AW];
  assign dec    = decode(opcode);

  generate
    if (PAD_MSB >= 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^bus.instruction[PAD_MSB:0];
    end
  endgenerate

  regfile_bypass #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .write_en   (bus.write_en),
    .write_addr (bus.write_addr),
    .write_data (bus.write_data),
    .raddr1     (rs1),
    .raddr2     (rs2),
    .rdata1     (rf_rdata1),
    .rdata2     (rf_rdata2)
  );

  // A load in EX cannot forward in time to the instruction in decode;
  // hold fetch for one cycle and let a bubble open the gap. A flush
  // kills the decode slot anyway, so it suppresses the stall.
  assign hazard_match = (dec.use_rs1 && (ex_dest_q == rs1)) ||
                        (dec.use_rs2 && (ex_dest_q == rs2));
  assign stall_int    = ex_valid_q & ex_ctrl_q.mem_read & ex_ctrl_q.wb & hazard_match &
                        bus.instr_valid & ~bus.jump_occured;
  assign bus.stall    = stall_int;

  // Bubbles clear only the valid/control bits; data fields keep their
  // last value since nothing downstream looks at them without ex_valid.
  always_comb begin
    ex_valid_d  = 1'b0;
    ex_ctrl_d   = '0;
    ex_rdata1_d = ex_rdata1_q;
    ex_rdata2_d = ex_rdata2_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_dest_d   = ex_dest_q;
    if (bus.instr_valid && !bus.jump_occured && !stall_int) begin
      ex_valid_d  = 1'b1;
      ex_ctrl_d   = dec;
      ex_rdata1_d = rf_rdata1;
      ex_rdata2_d = rf_rdata2;
      ex_rs1_d    = rs1;
      ex_rs2_d    = rs2;
      ex_dest_d   = rs1;
    end
  end

  always_comb begin
    chain_d[2] = '{valid:     ex_valid_q,
                   mem_read:  ex_ctrl_q.mem_read,
                   mem_write: ex_ctrl_q.mem_write,
                   wb:        ex_ctrl_q.wb,
                   dest:      ex_dest_q};
    for (int k = 3; k <= WB_DEPTH; k++) chain_d[k] = chain_q[k-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_dest_q   <= '0;
      for (int k = 2; k <= WB_DEPTH; k++) chain_q[k] <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rdata1_q <= ex_rdata1_d;
      ex_rdata2_q <= ex_rdata2_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_dest_q   <= ex_dest_d;
      chain_q     <= chain_d;
    end
  end

  logic unused_ex_use;
  assign unused_ex_use = ex_ctrl_q.use_rs1 ^ ex_ctrl_q.use_rs2;

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rdata1    = ex_rdata1_q;
  assign bus.ex_rdata2    = ex_rdata2_q;
  assign bus.ex_rs1       = ex_rs1_q;
  assign bus.ex_rs2       = ex_rs2_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.ex_alu_op    = ex_ctrl_q.alu_op;
  assign bus.ex_mem_read  = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write = ex_ctrl_q.mem_write;
  assign bus.ex_wb        = ex_ctrl_q.wb;
  assign bus.ex_push      = ex_ctrl_q.push;
  assign bus.ex_pop       = ex_ctrl_q.pop;
  assign bus.ex_in        = ex_ctrl_q.in;
  assign bus.ex_out       = ex_ctrl_q.out;
  assign bus.ex_jump_type = ex_ctrl_q.jump_type;

  assign bus.mem_valid    = chain_q[2].valid;
  assign bus.mem_read     = chain_q[2].mem_read;
  assign bus.mem_write    = chain_q[2].mem_write;
  assign bus.mem_wb       = chain_q[2].wb;
  assign bus.mem_dest     = chain_q[2].dest;

  assign bus.wb_valid     = chain_q[WB_DEPTH].valid;
  assign bus.wb_en        = chain_q[WB_DEPTH].wb;
  assign bus.wb_dest      = chain_q[WB_DEPTH].dest;

endmodule
